// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Writer side of the RV32I register file. Merges the
//                single-cycle ALU result path and the variable-latency load
//                path onto the register file's single write port. Load
//                results that lose arbitration are held in an in-order FIFO.
//                A pending-destination mask is exported so issue logic can
//                stall on registers that still have queued writes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   core clock, rising edge
//    reset        in   asynchronous active-high reset
//    alu_valid    in   ALU result present (always accepted)
//    alu_rd       in   ALU destination register
//    alu_data     in   ALU result
//    mem_valid    in   load result offered
//    mem_ready    out  load result can be accepted this cycle
//    mem_rd       in   load destination register
//    mem_data     in   load result
//    RegWrite     out  register-file write enable (registered)
//    rd           out  register-file write address (registered)
//    Result       out  register-file write data (registered)
//    pending_mask out  registers with a queued or in-flight write
//    fifo_count   out  occupied FIFO entries
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [4:0]                   mem_rd,
    input  logic [XLEN-1:0]              mem_data,
    output logic                         RegWrite,
    output logic [4:0]                   rd,
    output logic [XLEN-1:0]              Result,
    output logic [31:0]                  pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4:0]        r_fifo_rd   [DEPTH];
    logic [XLEN-1:0]   r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_reg_write;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              w_ready;
    logic              w_alu_ok;
    logic              w_load_ok;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic [4:0]        w_wr_rd;
    logic [XLEN-1:0]   w_wr_data;

    // Ready depends only on occupancy; a same-cycle pop does not free a slot
    // early, which keeps mem_ready free of any path from alu_valid.
    assign w_ready   = (r_count < CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_alu_ok  = alu_valid && (alu_rd != 5'd0);
    // Accepted loads to x0 complete the handshake but are dropped here.
    assign w_load_ok = mem_valid && w_ready && (mem_rd != 5'd0);

    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_rd   = r_rd;
        w_wr_data = r_result;
        if (w_alu_ok) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = alu_rd;
            w_wr_data = alu_data;
            w_push    = w_load_ok;
        end else if (!w_empty) begin
            // Queued loads drain before a new load so load order is kept.
            w_pop     = 1'b1;
            w_wr_en   = 1'b1;
            w_wr_rd   = r_fifo_rd[r_rptr];
            w_wr_data = r_fifo_data[r_rptr];
            w_push    = w_load_ok;
        end else if (w_load_ok) begin
            w_wr_en   = 1'b1;
            w_wr_rd   = mem_rd;
            w_wr_data = mem_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (payload needs no reset; validity comes from r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mem_rd;
            r_fifo_data[r_wptr] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count and output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_reg_write <= 1'b0;
            r_rd        <= 5'd0;
            r_result    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_reg_write <= w_wr_en;
            if (w_wr_en) begin
                r_rd     <= w_wr_rd;
                r_result <= w_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination mask
    // ------------------------------------------------------------------
    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy count.
    logic [DEPTH-1:0] w_slot_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off           = PTR_W'(i) - r_rptr;
        assign w_slot_valid[i] = ({1'b0, w_off} < r_count);
    end

    logic [31:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                w_mask[r_fifo_rd[i]] = 1'b1;
            end
        end
        if (r_reg_write) begin
            w_mask[r_rd] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_ready    = w_ready;
    assign RegWrite     = r_reg_write;
    assign rd           = r_rd;
    assign Result       = r_result;
    assign pending_mask = w_mask;
    assign fifo_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//                Inputs change 1 ns after a rising edge; outputs are
//                sampled at that same point, away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              clk;
    logic              reset;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              RegWrite;
    logic [4:0]        rd;
    logic [XLEN-1:0]   Result;
    logic [31:0]       pending_mask;
    logic [2:0]        fifo_count;

    int n_checks;
    int n_fail;

    regfile_wb_arbiter #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .RegWrite     (RegWrite),
        .rd           (rd),
        .Result       (Result),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = '0;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".we"},  32'(RegWrite), 32'(we));
        check({tag, ".rd"},  32'(rd),       32'(r));
        check({tag, ".res"}, Result,        d);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();

        // ---------------- reset state ----------------
        #12;
        check("rst.we",    32'(RegWrite),     32'd0);
        check("rst.rd",    32'(rd),           32'd0);
        check("rst.res",   Result,            32'd0);
        check("rst.cnt",   32'(fifo_count),   32'd0);
        check("rst.mask",  pending_mask,      32'd0);
        reset = 1'b0;
        step();
        check("rst.ready", 32'(mem_ready),    32'd1);

        // ---------------- ALU only ----------------
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        check_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        check("alu.mask", pending_mask, 32'h0000_0020);
        idle_inputs();
        step();
        check_wr("alu_idle", 1'b0, 5'd5, 32'hDEADBEEF);
        check("alu_idle.mask", pending_mask, 32'h0);

        // ---------------- load bypass ----------------
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12345678;
        check("byp.ready", 32'(mem_ready), 32'd1);
        step();
        check_wr("byp", 1'b1, 5'd7, 32'h12345678);
        check("byp.cnt", 32'(fifo_count), 32'd0);
        idle_inputs();
        step();

        // ---------------- collision ----------------
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
        step();
        check_wr("col1", 1'b1, 5'd3, 32'h11);
        check("col1.cnt",  32'(fifo_count), 32'd1);
        check("col1.mask", pending_mask,    32'h0000_0018);
        idle_inputs();
        step();
        check_wr("col2", 1'b1, 5'd4, 32'h22);
        check("col2.cnt",  32'(fifo_count), 32'd0);
        check("col2.mask", pending_mask,    32'h0000_0010);
        step();
        check("col3.we",   32'(RegWrite),   32'd0);
        check("col3.mask", pending_mask,    32'h0);

        // ---------------- fill and backpressure ----------------
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(10 + k); mem_data = 32'hA0 + 32'(k);
            check($sformatf("fill%0d.ready", k), 32'(mem_ready), 32'd1);
            step();
            check($sformatf("fill%0d.cnt", k), 32'(fifo_count), 32'(k + 1));
        end
        mem_rd = 5'd14; mem_data = 32'hA4;
        check("full.ready", 32'(mem_ready),  32'd0);
        check("full.mask",  pending_mask,    32'h0000_3C02);
        check_wr("full", 1'b1, 5'd1, 32'h100);
        alu_valid = 1'b0;
        step();
        check_wr("drain10", 1'b1, 5'd10, 32'hA0);
        check("drain10.cnt",   32'(fifo_count), 32'd3);
        check("drain10.ready", 32'(mem_ready),  32'd1);
        step();
        check_wr("drain11", 1'b1, 5'd11, 32'hA1);
        check("drain11.cnt", 32'(fifo_count), 32'd3);
        idle_inputs();
        step();
        check_wr("drain12", 1'b1, 5'd12, 32'hA2);
        check("drain12.cnt", 32'(fifo_count), 32'd2);
        step();
        check_wr("drain13", 1'b1, 5'd13, 32'hA3);
        step();
        check_wr("drain14", 1'b1, 5'd14, 32'hA4);
        check("drain14.cnt",  32'(fifo_count), 32'd0);
        check("drain14.mask", pending_mask,    32'h0000_4000);
        step();
        check("drained.we", 32'(RegWrite), 32'd0);

        // ---------------- rd == 0 handling ----------------
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h202;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h909;
        step();
        check_wr("x0pre", 1'b1, 5'd2, 32'h202);
        check("x0pre.cnt", 32'(fifo_count), 32'd1);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0;
        step();
        check_wr("aluX0", 1'b1, 5'd9, 32'h909);
        check("aluX0.cnt", 32'(fifo_count), 32'd0);
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
        check("memX0.ready", 32'(mem_ready), 32'd1);
        step();
        check("memX0.we",   32'(RegWrite),   32'd0);
        check("memX0.cnt",  32'(fifo_count), 32'd0);
        check("memX0.mask", pending_mask,    32'h0);
        idle_inputs();
        step();

        // ---------------- async reset mid-drain ----------------
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h111;
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_data = 32'hC0 + 32'(k);
            step();
        end
        idle_inputs();
        check("pre_rst.cnt",  32'(fifo_count), 32'd3);
        check("pre_rst.mask", pending_mask,    32'h0070_0002);
        #2;
        reset = 1'b1;
        #1;
        check_wr("arst", 1'b0, 5'd0, 32'h0);
        check("arst.cnt",  32'(fifo_count), 32'd0);
        check("arst.mask", pending_mask,    32'h0);
        #2;
        reset = 1'b0;
        step();
        check("post_rst.we",    32'(RegWrite),  32'd0);
        check("post_rst.ready", 32'(mem_ready), 32'd1);
        step();
        check("post_rst2.we",   32'(RegWrite),  32'd0);
        check("post_rst2.cnt",  32'(fifo_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer side of the RV32I register file. Merges two result producers into the file's single write port (RegWrite/rd/Result):
  - the single-cycle ALU path;
  - the variable-latency load/LSU path.
- Load results that lose arbitration are buffered in a small in-order FIFO.
- Exports a pending-destination mask so issue logic can stall on registers that still have queued writes.

Parameters:
- DEPTH, 4, number of buffered load results (power of two, 2..16).
- XLEN, 32, data width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- alu_valid  input  1  ALU result present this cycle; always accepted (no ready).
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  arbiter can accept a load result this cycle.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load result.
- RegWrite  output  1  register-file write enable (registered).
- rd  output  5  register-file write address (registered).
- Result  output  XLEN  register-file write data (registered).
- pending_mask  output  32  bit r = 1 while any FIFO entry or the output stage targets register r.
- fifo_count  output  clog2(DEPTH+1)  occupied FIFO entries.

Behaviour:

Reset and output stage:
- Reset (async): RegWrite=0, rd=0, Result=0, FIFO read/write pointers=0, count=0, pending_mask=0, mem_ready=1 once reset deasserts. Reset mid-operation discards all queued loads with no partial write.
- Output stage is one register: RegWrite/rd/Result update every clock edge. RegWrite=0 on cycles with no selected write. rd and Result hold their previous values when RegWrite=0.

Handshakes:
- Load handshake: a transfer occurs when mem_valid && mem_ready. The source holds mem_rd/mem_data stable while mem_valid && !mem_ready.
- mem_ready = (count < DEPTH). It is not relaxed by a same-cycle pop.

rd == 0 handling:
- ALU with alu_rd==0: ignored entirely; treated as alu_valid=0.
- Load with mem_rd==0 that is accepted: discarded; no enqueue, no write.

Selection each cycle (at most one write), highest priority first:
1. alu_valid (rd≠0): write ALU result. An accepted load (rd≠0) is enqueued.
2. FIFO non-empty: pop head and write it. An accepted load is enqueued behind it, preserving load order.
3. FIFO empty and load accepted: bypass; write load result directly, no enqueue.
4. Otherwise: RegWrite=0.

Latency and FIFO rules:
- Latency: 1 cycle from accept/selection to RegWrite=1 at the register file.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Full FIFO (count==DEPTH): mem_ready=0. Pops continue on any cycle without ALU activity.

pending_mask:
- Combinational OR of one-hot(rd) over valid FIFO entries, plus one-hot(rd) of the output stage when RegWrite=1. Bit 0 is always 0.
- Ordering between an in-flight load and a younger ALU write to the same rd is the issue logic's responsibility via pending_mask; the arbiter does not reorder or squash.

Arithmetic:
- count is (clog2(DEPTH)+1) bits.
- Result is passed through unmodified; no sign/zero extension here.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → next cycle RegWrite=1, rd=5, Result=0xDEADBEEF; following cycle RegWrite=0.
- Load bypass: FIFO empty, mem_valid=1, mem_rd=7, mem_data=0x12345678, alu_valid=0 → mem_ready=1, next cycle write x7=0x12345678, fifo_count stays 0.
- Collision: same cycle alu (rd=3, 0x11) and load (rd=4, 0x22) → cycle+1 writes x3=0x11, cycle+2 writes x4=0x22; pending_mask bit 4 = 1 from cycle+1 until the write cycle ends.
- Fill and backpressure: alu_valid held 1 (rd=1) while 5 loads (rd=10..14) are offered → first 4 accepted, mem_ready=0 with fifo_count=4. Drop alu_valid → loads written x10..x13 in order, 5th load accepted once count<4, x14 written last.
- rd==0: alu_rd=0 with alu_valid=1 and FIFO holding rd=9 → FIFO head pops, x9 written next cycle. Load with mem_rd=0 accepted → no RegWrite, fifo_count unchanged.
- Async reset mid-drain: fifo_count=3, assert reset between edges → RegWrite, rd, Result, fifo_count and pending_mask go to 0 immediately. No writes after release until new input arrives.
